id_ex_stage: RTL and testbench

- Single-entry ID/EX pipeline register that feeds the 32-bit ALU.
- Captures decoded register operands, the immediate, ALU select and writeback control from decode.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Presents A/B operands and ALU_Sel to the ALU with a valid/ready handshake; supports stall and flush.

---
 rtl/datapath_pkg.sv | 19 +
 rtl/id_ex_stage_fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath widths and ALU operation codes for the execute stage.
package datapath_pkg;

   localparam int DW   = 32;
   localparam int RW   = 5;
   localparam int SELW = 4;

   // Any code not listed makes the ALU pass operand A through unchanged.
   typedef enum logic [SELW-1:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100,
      ALU_EQ  = 4'b1111
   } alu_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forward select: EX/MEM beats MEM/WB, register 0 is never forwarded.
// Latency: combinational. Backpressure: none, pure select.
module fwd_mux
   import datapath_pkg::*;
#(
   parameter int DW = datapath_pkg::DW,
   parameter int RW = datapath_pkg::RW
) (
   input  logic [RW-1:0] src_addr,
   input  logic [DW-1:0] rf_data,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd_addr,
   input  logic [DW-1:0] exm_result,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] wb_rd_addr,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] fwd_data
);

   always_comb begin
      fwd_data = rf_data;
      if (src_addr != '0) begin
         if (exm_reg_write && (exm_rd_addr == src_addr))
            fwd_data = exm_result;
         else if (wb_reg_write && (wb_rd_addr == src_addr))
            fwd_data = wb_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU; forwarding and held-entry snoop under ID_EX_FWD_EN.
// Latency: 1 cycle, 1 instruction per cycle. Backpressure: in_ready = !flush && (!out_valid || out_ready).
// A held entry keeps its control fields; its operands may still pick up late forwarded results.
module id_ex_stage
   import datapath_pkg::*;
#(
   parameter int DW   = datapath_pkg::DW,
   parameter int RW   = datapath_pkg::RW,
   parameter int SELW = datapath_pkg::SELW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RW-1:0]   in_rs_addr,
   input  logic [RW-1:0]   in_rt_addr,
   input  logic [DW-1:0]   in_rs_data,
   input  logic [DW-1:0]   in_rt_data,
   input  logic [DW-1:0]   in_imm,
   input  logic            in_alu_src,
   input  logic [SELW-1:0] in_alu_sel,
   input  logic [RW-1:0]   in_rd_addr,
   input  logic            in_reg_write,
   input  logic            flush,
   input  logic            exm_reg_write,
   input  logic [RW-1:0]   exm_rd_addr,
   input  logic [DW-1:0]   exm_result,
   input  logic            wb_reg_write,
   input  logic [RW-1:0]   wb_rd_addr,
   input  logic [DW-1:0]   wb_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   A_out,
   output logic [DW-1:0]   B_out,
   output logic [SELW-1:0] ALU_Sel_out,
   output logic [DW-1:0]   store_data_out,
   output logic [RW-1:0]   rd_addr_out,
   output logic            reg_write_out
);

   logic          capture;
   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;
   logic [DW-1:0] b_sel;

   assign in_ready = !flush && (!out_valid || out_ready);
   assign capture  = in_valid && in_ready;

`ifdef ID_EX_FWD_EN
   logic [RW-1:0] rs_q;
   logic [RW-1:0] rt_q;
   logic          alu_src_q;
   logic [DW-1:0] snoop_rs;
   logic [DW-1:0] snoop_rt;

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .src_addr(in_rs_addr), .rf_data(in_rs_data),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
      .fwd_data(fwd_rs)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .src_addr(in_rt_addr), .rf_data(in_rt_data),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
      .fwd_data(fwd_rt)
   );

   // Snoop falls back to the held operand itself when nothing matches.
   fwd_mux #(.DW(DW), .RW(RW)) u_snoop_rs (
      .src_addr(rs_q), .rf_data(A_out),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
      .fwd_data(snoop_rs)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_snoop_rt (
      .src_addr(rt_q), .rf_data(store_data_out),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
      .fwd_data(snoop_rt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rs_q      <= '0;
         rt_q      <= '0;
         alu_src_q <= 1'b0;
      end else if (capture) begin
         rs_q      <= in_rs_addr;
         rt_q      <= in_rt_addr;
         alu_src_q <= in_alu_src;
      end
   end
`else
   logic unused_fwd;

   assign fwd_rs     = in_rs_data;
   assign fwd_rt     = in_rt_data;
   assign unused_fwd = ^{in_rs_addr, in_rt_addr, exm_reg_write, exm_rd_addr, exm_result,
                         wb_reg_write, wb_rd_addr, wb_result};
`endif

   assign b_sel = in_alu_src ? in_imm : fwd_rt;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid      <= 1'b0;
         A_out          <= '0;
         B_out          <= '0;
         store_data_out <= '0;
         ALU_Sel_out    <= '0;
         rd_addr_out    <= '0;
         reg_write_out  <= 1'b0;
      end else if (flush) begin
         out_valid      <= 1'b0;
      end else if (capture) begin
         out_valid      <= 1'b1;
         A_out          <= fwd_rs;
         B_out          <= b_sel;
         store_data_out <= fwd_rt;
         ALU_Sel_out    <= in_alu_sel;
         rd_addr_out    <= in_rd_addr;
         reg_write_out  <= in_reg_write;
      end else if (out_valid && out_ready) begin
         out_valid      <= 1'b0;
`ifdef ID_EX_FWD_EN
      end else if (out_valid) begin
         A_out          <= snoop_rs;
         store_data_out <= snoop_rt;
         if (!alu_src_q)
            B_out       <= snoop_rt;
`endif
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of back-to-back vectors plus hold, snoop, flush and reset sequences.
module tb_id_ex_stage;
   import datapath_pkg::*;

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
   logic [31:0] in_rs_data, in_rt_data, in_imm;
   logic        in_alu_src, in_reg_write;
   logic [3:0]  in_alu_sel;
   logic        flush;
   logic        exm_reg_write, wb_reg_write;
   logic [4:0]  exm_rd_addr, wb_rd_addr;
   logic [31:0] exm_result, wb_result;
   logic        out_valid, out_ready;
   logic [31:0] A_out, B_out, store_data_out;
   logic [3:0]  ALU_Sel_out;
   logic [4:0]  rd_addr_out;
   logic        reg_write_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_sel(in_alu_sel),
      .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
      .flush(flush),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .A_out(A_out), .B_out(B_out), .ALU_Sel_out(ALU_Sel_out),
      .store_data_out(store_data_out), .rd_addr_out(rd_addr_out),
      .reg_write_out(reg_write_out)
   );

   typedef struct {
      logic [4:0]  rs, rt, rd, erd, wrd;
      logic [31:0] rsd, rtd, imm, eres, wres;
      logic        src, rw, ew, ww;
      logic [3:0]  sel;
      logic [31:0] ea, eb, esd;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs[NV];

   function automatic vec_t mk(
      input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
      input logic [31:0] imm, input logic src, input logic [3:0] sel, input logic [4:0] rd,
      input logic rw, input logic ew, input logic [4:0] erd, input logic [31:0] eres,
      input logic ww, input logic [4:0] wrd, input logic [31:0] wres,
      input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] esd);
      vec_t v;
      v.rs = rs;   v.rsd = rsd; v.rt = rt;   v.rtd = rtd; v.imm = imm; v.src = src;
      v.sel = sel; v.rd = rd;   v.rw = rw;   v.ew = ew;   v.erd = erd; v.eres = eres;
      v.ww = ww;   v.wrd = wrd; v.wres = wres;
      v.ea = ea;   v.eb = eb;   v.esd = esd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
      in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_alu_src = 0;
      in_reg_write = 0; in_alu_sel = 0; flush = 0;
      exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
      wb_reg_write = 0; wb_rd_addr = 0; wb_result = 0;
      out_ready = 1;
   endtask

   task automatic apply(input vec_t v);
      in_valid = 1;
      in_rs_addr = v.rs; in_rs_data = v.rsd; in_rt_addr = v.rt; in_rt_data = v.rtd;
      in_imm = v.imm; in_alu_src = v.src; in_alu_sel = v.sel;
      in_rd_addr = v.rd; in_reg_write = v.rw;
      exm_reg_write = v.ew; exm_rd_addr = v.erd; exm_result = v.eres;
      wb_reg_write = v.ww; wb_rd_addr = v.wrd; wb_result = v.wres;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_A"},     A_out, 32'd0);
      chk({tag, "_B"},     B_out, 32'd0);
      chk({tag, "_sd"},    store_data_out, 32'd0);
      chk({tag, "_sel"},   32'(ALU_Sel_out), 32'd0);
      chk({tag, "_rd"},    32'(rd_addr_out), 32'd0);
      chk({tag, "_rw"},    32'(reg_write_out), 32'd0);
   endtask

   initial begin
      vecs[0] = mk(5'd3, 32'h10, 5'd4, 32'h20, 32'h0, 1'b0, ALU_ADD, 5'd1, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h10, 32'h20, 32'h20);
      vecs[1] = mk(5'd5, 32'h5, 5'd6, 32'h66, 32'h0, 1'b0, ALU_SUB, 5'd2, 1'b1,
                   1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
                   FWD ? 32'hAAAA : 32'h5, 32'h66, 32'h66);
      vecs[2] = mk(5'd0, 32'h77, 5'd9, 32'h99, 32'h0, 1'b0, ALU_AND, 5'd4, 1'b0,
                   1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF,
                   32'h77, 32'h99, 32'h99);
      vecs[3] = mk(5'd2, 32'h22, 5'd8, 32'h8, 32'hFFFF_FFF0, 1'b1, ALU_SLT, 5'd5, 1'b1,
                   1'b1, 5'd8, 32'h55, 1'b0, 5'd0, 32'h0,
                   32'h22, 32'hFFFF_FFF0, FWD ? 32'h55 : 32'h8);
      vecs[4] = mk(5'd10, 32'h1, 5'd11, 32'h2, 32'h0, 1'b0, ALU_OR, 5'd6, 1'b1,
                   1'b0, 5'd10, 32'hAAAA, 1'b1, 5'd10, 32'hBBBB,
                   FWD ? 32'hBBBB : 32'h1, 32'h2, 32'h2);
      vecs[5] = mk(5'd12, 32'h3, 5'd13, 32'h4, 32'h0, 1'b0, ALU_NOR, 5'd31, 1'b0,
                   1'b1, 5'd13, 32'hC0DE, 1'b1, 5'd12, 32'hF00D,
                   FWD ? 32'hF00D : 32'h3, FWD ? 32'hC0DE : 32'h4, FWD ? 32'hC0DE : 32'h4);
      vecs[6] = mk(5'd14, 32'hA, 5'd15, 32'hB, 32'h1234, 1'b1, ALU_EQ, 5'd7, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'hA, 32'h1234, 32'hB);

      idle_inputs();
      reset = 1;
      tick();
      tick();
      chk_zero("reset");
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      reset = 0;

      // Back-to-back stream: one output per cycle, in order.
      for (int i = 0; i < NV; i++) begin
         apply(vecs[i]);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_A", i),     A_out, vecs[i].ea);
         chk($sformatf("v%0d_B", i),     B_out, vecs[i].eb);
         chk($sformatf("v%0d_sd", i),    store_data_out, vecs[i].esd);
         chk($sformatf("v%0d_sel", i),   32'(ALU_Sel_out), 32'(vecs[i].sel));
         chk($sformatf("v%0d_rd", i),    32'(rd_addr_out), 32'(vecs[i].rd));
         chk($sformatf("v%0d_rw", i),    32'(reg_write_out), 32'(vecs[i].rw));
      end
      idle_inputs();
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_A_hold", A_out, 32'hA);

      // Hold with rt snooped from MEM/WB one cycle later.
      in_valid = 1; in_rs_addr = 5'd1; in_rs_data = 32'h11; in_rt_addr = 5'd7; in_rt_data = 32'h70;
      in_alu_sel = ALU_SUB; in_rd_addr = 5'd3; in_reg_write = 1; out_ready = 0;
      tick();
      chk("hold_cap_valid", 32'(out_valid), 32'd1);
      chk("hold_cap_B", B_out, 32'h70);
      in_rs_data = 32'h999; in_rt_addr = 5'd9; in_alu_sel = ALU_AND; in_rd_addr = 5'd8;
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("hold_A_stable", A_out, 32'h11);
      chk("hold_B_stable", B_out, 32'h70);
      wb_reg_write = 1; wb_rd_addr = 5'd7; wb_result = 32'h1234;
      tick();
      chk("snoop_B", B_out, FWD ? 32'h1234 : 32'h70);
      chk("snoop_sd", store_data_out, FWD ? 32'h1234 : 32'h70);
      chk("snoop_A", A_out, 32'h11);
      chk("snoop_sel", 32'(ALU_Sel_out), 32'(ALU_SUB));
      chk("snoop_rd", 32'(rd_addr_out), 32'd3);
      chk("snoop_valid", 32'(out_valid), 32'd1);
      chk("snoop_in_ready", 32'(in_ready), 32'd0);
      wb_reg_write = 0;
      tick();
      chk("snoop_B_kept", B_out, FWD ? 32'h1234 : 32'h70);
      reset = 1;
      tick();
      chk_zero("reset_hold");
      reset = 0;

      // Held entry with immediate B: only store data follows the forward.
      idle_inputs();
      in_valid = 1; in_rt_addr = 5'd7; in_rt_data = 32'h70; in_alu_src = 1;
      in_imm = 32'hFFFF_FFF0; out_ready = 0;
      tick();
      in_valid = 0;
      exm_reg_write = 1; exm_rd_addr = 5'd7; exm_result = 32'h55;
      wb_reg_write = 1; wb_rd_addr = 5'd7; wb_result = 32'h66;
      tick();
      chk("imm_hold_B", B_out, 32'hFFFF_FFF0);
      chk("imm_hold_sd", store_data_out, FWD ? 32'h55 : 32'h70);
      out_ready = 1; exm_reg_write = 0; wb_reg_write = 0;
      tick();
      chk("release_valid", 32'(out_valid), 32'd0);

      // Flush beats a held entry and a simultaneous input.
      idle_inputs();
      in_valid = 1; in_rs_addr = 5'd1; in_rs_data = 32'h33; out_ready = 0;
      tick();
      chk("flush_pre_valid", 32'(out_valid), 32'd1);
      flush = 1; in_rs_data = 32'h44;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush = 0; in_valid = 0;
      tick();
      chk("flush_no_capture_valid", 32'(out_valid), 32'd0);
      chk("flush_no_capture_A", A_out, 32'h33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
